// File: rtl/rr_pkt_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// xsw_arb_pkg
//   Types and helpers shared by the switch arbiters.
//   - arb_state_e : packet arbiter FSM state (IDLE / LOCKED)
//   - oh2idx      : one-hot to binary encoder over a fixed maximum width
//                   (ARB_MAX_N); callers zero-extend narrower vectors and
//                   slice the result down to their own index width.
// -----------------------------------------------------------------------------
package xsw_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Largest requester count the shared encoder supports.
    localparam int ARB_MAX_N    = 64;
    localparam int ARB_MAX_IDXW = 6;

    // OR-reduction encoder: valid only for one-hot (or zero) input, which
    // keeps it free of any priority chain.
    function automatic logic [ARB_MAX_IDXW-1:0] oh2idx(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_MAX_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_MAX_IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pkt_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_pkt_arbiter_if
//   Request/grant bundle between N packet sources and one output port.
//   Signals:
//     req_vld  [N]    per-requester flit valid           (source -> arbiter)
//     req_last [N]    per-requester last-flit flag       (source -> arbiter)
//     req_rdy  [N]    per-requester accept, one-hot0     (arbiter -> source)
//     out_rdy         downstream ready                   (sink   -> arbiter)
//     gnt_vld         a grant is held                    (arbiter -> all)
//     gnt_oh   [N]    one-hot current winner             (arbiter -> all)
//     gnt_idx  [IDXW] binary index of gnt_oh             (arbiter -> all)
//   Modports:
//     master : the request/downstream side that drives the arbiter
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface rr_pkt_arbiter_if #(
    parameter int N    = 8,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) ();

    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_rdy;
    logic            out_rdy;
    logic            gnt_vld;
    logic [N-1:0]    gnt_oh;
    logic [IDXW-1:0] gnt_idx;

    modport master (
        output req_vld,
        output req_last,
        output out_rdy,
        input  req_rdy,
        input  gnt_vld,
        input  gnt_oh,
        input  gnt_idx
    );

    modport slave (
        input  req_vld,
        input  req_last,
        input  out_rdy,
        output req_rdy,
        output gnt_vld,
        output gnt_oh,
        output gnt_idx
    );

endinterface

// File: rtl/rr_pkt_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin winner pick from a thermometer priority mask.
//   The mask marks requesters that are "after" the previous winner; if none
//   of them is requesting, the pick falls back to the unmasked request set.
//   The lowest set bit of the chosen set wins: prefix-OR fill upward, then
//   keep only the rising edge of the fill.
//   Ports:
//     req_i      [N]    request vector
//     pri_mask_i [N]    thermometer priority mask
//     oh_o       [N]    one-hot winner (zero when no request)
//     idx_o      [IDXW] binary index of oh_o
//     any_o             at least one request present
//   N is limited to xsw_arb_pkg::ARB_MAX_N.
// -----------------------------------------------------------------------------
module rr_pick
    import xsw_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    pri_mask_i,
    output logic [N-1:0]    oh_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [N-1:0]            masked;
    logic [N-1:0]            src;
    logic [N-1:0]            fill;
    logic [ARB_MAX_N-1:0]    oh_ext;
    logic [ARB_MAX_IDXW-1:0] idx_full;
    logic                    unused_idx_bits;

    assign masked = req_i & pri_mask_i;
    assign src    = (|masked) ? masked : req_i;

    // fill[i] = |src[i:0]; the chain lives in one block so the tool sees a
    // single combinational function rather than a self-referencing net.
    always_comb begin
        fill = src;
        for (int i = 1; i < N; i++) begin
            fill[i] = fill[i-1] | src[i];
        end
    end

    // Edge extract: oh = fill & ~(fill << 1).
    assign oh_o[0] = fill[0];
    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_edge
            assign oh_o[gi] = fill[gi] & ~fill[gi-1];
        end
    endgenerate

    always_comb begin
        oh_ext        = '0;
        oh_ext[N-1:0] = oh_o;
    end

    assign idx_full        = oh2idx(oh_ext);
    assign idx_o           = idx_full[IDXW-1:0];
    // Upper encoder bits are always zero for N below the maximum.
    assign unused_idx_bits = ^idx_full;

    assign any_o = |req_i;

endmodule

// File: rtl/rr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pkt_arbiter
//   Packet-granular round-robin arbiter for one switch output port. A winner
//   is picked from the idle state, the grant is held until that requester's
//   last flit is accepted downstream, and the priority mask then moves to
//   the requesters strictly above the finished winner. One idle cycle
//   separates consecutive packets.
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous active-high reset; assertion clears the grant
//             immediately, release is expected to be synchronous to clk
//     arb     rr_pkt_arbiter_if.slave request/grant bundle
//   Parameters:
//     N       number of requesters (>= 1)
//     IDXW    grant index width (1 when N == 1)
// -----------------------------------------------------------------------------
module rr_pkt_arbiter
    import xsw_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    rr_pkt_arbiter_if.slave   arb
);

    arb_state_e      state_q;
    logic [N-1:0]    pri_mask_q;
    logic [N-1:0]    pri_mask_d;
    logic            gnt_vld_q;
    logic [N-1:0]    gnt_oh_q;
    logic [IDXW-1:0] gnt_idx_q;

    logic [N-1:0]    pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    logic            xfer;
    logic            last_xfer;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req_i      (arb.req_vld),
        .pri_mask_i (pri_mask_q),
        .oh_o       (pick_oh),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    // A flit moves only from the held winner, and only when it is valid and
    // downstream is ready. req_last counts only together with req_vld.
    assign xfer      = arb.out_rdy & |(arb.req_vld & gnt_oh_q);
    assign last_xfer = xfer & |(arb.req_vld & arb.req_last & gnt_oh_q);

    // Mask for the next round: bits strictly above the current winner.
    // A winner at N-1 leaves an empty mask, which makes the picker fall back
    // to the lowest active request.
    always_comb begin
        pri_mask_d = '0;
        for (int i = 1; i < N; i++) begin
            pri_mask_d[i] = pri_mask_d[i-1] | gnt_oh_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            pri_mask_q <= '1;
            gnt_vld_q  <= 1'b0;
            gnt_oh_q   <= '0;
            gnt_idx_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_q   <= ARB_LOCKED;
                        gnt_vld_q <= 1'b1;
                        gnt_oh_q  <= pick_oh;
                        gnt_idx_q <= pick_idx;
                    end
                end
                ARB_LOCKED: begin
                    // Stalls (out_rdy low or winner not valid) simply hold.
                    if (last_xfer) begin
                        state_q    <= ARB_IDLE;
                        gnt_vld_q  <= 1'b0;
                        gnt_oh_q   <= '0;
                        gnt_idx_q  <= '0;
                        pri_mask_q <= pri_mask_d;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // gnt_oh_q is zero outside LOCKED, so the state gate is redundant in
    // function but keeps the intent explicit.
    assign arb.req_rdy = (state_q == ARB_LOCKED) ? (gnt_oh_q & {N{arb.out_rdy}}) : '0;
    assign arb.gnt_vld = gnt_vld_q;
    assign arb.gnt_oh  = gnt_oh_q;
    assign arb.gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_pkt_arbiter
//   Directed scenarios for a 4-requester arbiter. A behavioural upstream
//   holds per-requester packet queues and presents flits until accepted.
//   Each scenario pushes the hand-derived grant order (requester, flit
//   count) into a scoreboard; a monitor pops an entry at every new grant
//   and checks the grant, req_rdy and the number of flits moved.
// -----------------------------------------------------------------------------
module tb_rr_pkt_arbiter;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_pkt_arbiter_if #(.N(N), .IDXW(IDXW)) arb ();

    rr_pkt_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    typedef struct {
        int idx;
        int flits;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pkt_q[N][$];
    int          remaining[N];
    logic [N-1:0] hold;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    function automatic int enc(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Recompute the upstream drive from the packet state.
    task automatic upd();
        logic [N-1:0] v;
        logic [N-1:0] l;
        for (int i = 0; i < N; i++) begin
            if (remaining[i] == 0 && pkt_q[i].size() > 0) begin
                remaining[i] = int'(pkt_q[i].pop_front());
            end
            v[i] = (remaining[i] != 0) && !hold[i];
            // While held, drive last without valid: it must have no effect.
            l[i] = (remaining[i] == 1) || hold[i];
        end
        arb.req_vld  = v;
        arb.req_last = l;
    endtask

    // One clock: capture accepted flits before the edge, update after it.
    task automatic step();
        logic [N-1:0] x;
        @(negedge clk);
        x = arb.req_vld & arb.req_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (x[i] && remaining[i] > 0) remaining[i]--;
        end
        upd();
    endtask

    task automatic wait_idle(input string name);
        int  n;
        bit  idle;
        for (n = 0; n < 200; n++) begin
            idle = !arb.gnt_vld && (exp_q.size() == 0) && (hold == '0);
            for (int i = 0; i < N; i++) begin
                if (remaining[i] != 0 || pkt_q[i].size() != 0) idle = 1'b0;
            end
            if (idle) break;
            step();
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual=busy required=idle within 200 cycles", name);
        end
    endtask

    task automatic push_exp(input int idx, input int flits);
        exp_t e;
        e.idx   = idx;
        e.flits = flits;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor.
    initial begin
        logic         prev_vld;
        logic [N-1:0] prev_oh;
        logic [N-1:0] exp_oh;
        int           bubble;
        int           flits;
        bit           have;
        exp_t         cur;
        prev_vld = 1'b0;
        prev_oh  = '0;
        bubble   = 0;
        flits    = 0;
        have     = 1'b0;
        cur.idx  = 0;
        cur.flits = 0;
        forever begin
            @(negedge clk);
            if (rst) bubble = 0;
            if (arb.gnt_vld && !prev_vld) begin
                chk("arb_latency_cycles", bubble, 1);
                bubble = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: actual=%0d required=none", arb.gnt_idx);
                end else begin
                    cur   = exp_q.pop_front();
                    have  = 1'b1;
                    flits = 0;
                end
            end
            if (!arb.gnt_vld && prev_vld && have) begin
                chk("pkt_flits", flits, cur.flits);
                $display("grant req%0d done: flits=%0d expected=%0d", cur.idx, flits, cur.flits);
                have = 1'b0;
            end
            chk("gnt_oh_onehot0", 32'($onehot0(arb.gnt_oh)), 1);
            chk("req_rdy_onehot0", 32'($onehot0(arb.req_rdy)), 1);
            chk("gnt_idx_encode", arb.gnt_idx, enc(arb.gnt_oh));
            if (prev_vld && arb.gnt_vld) chk("gnt_stable", arb.gnt_oh, prev_oh);
            if (have) begin
                exp_oh = N'(1) << cur.idx;
                chk("gnt_oh", arb.gnt_oh, exp_oh);
                chk("gnt_idx", arb.gnt_idx, cur.idx);
                chk("req_rdy", arb.req_rdy, exp_oh & {N{arb.out_rdy}});
                if (|(arb.req_vld & arb.req_rdy)) flits++;
            end else begin
                chk("gnt_oh_idle", arb.gnt_oh, 0);
                chk("req_rdy_idle", arb.req_rdy, 0);
            end
            if (!arb.gnt_vld && !rst && |arb.req_vld) bubble++;
            prev_vld = arb.gnt_vld;
            prev_oh  = arb.gnt_oh;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] pat;
        rst         = 1'b1;
        hold        = '0;
        arb.out_rdy = 1'b1;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        upd();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt_vld", arb.gnt_vld, 0);
        chk("rst_gnt_oh", arb.gnt_oh, 0);
        chk("rst_gnt_idx", arb.gnt_idx, 0);
        chk("rst_req_rdy", arb.req_rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // S1: 0110 -> grant 1 one cycle later; mask becomes 1100, so 2 next.
        push_exp(1, 1);
        push_exp(2, 1);
        pkt_q[1].push_back(1);
        pkt_q[2].push_back(1);
        upd();
        #1;
        chk("s1_gnt_vld_same_cycle", arb.gnt_vld, 0);
        step();
        #1;
        chk("s1_gnt_vld", arb.gnt_vld, 1);
        chk("s1_gnt_oh", arb.gnt_oh, 4'b0010);
        chk("s1_gnt_idx", arb.gnt_idx, 1);
        wait_idle("s1");

        // S2: rotation from mask 1000, all requesting two 1-flit packets.
        push_exp(3, 1); push_exp(0, 1); push_exp(1, 1); push_exp(2, 1);
        push_exp(3, 1); push_exp(0, 1); push_exp(1, 1); push_exp(2, 1);
        for (int i = 0; i < N; i++) begin
            pkt_q[i].push_back(1);
            pkt_q[i].push_back(1);
        end
        upd();
        wait_idle("s2");

        // S3: 3 wins from mask 1000, empty mask falls back to 0, then 2.
        push_exp(3, 1); push_exp(0, 1); push_exp(2, 1);
        pkt_q[3].push_back(1);
        pkt_q[0].push_back(1);
        pkt_q[2].push_back(1);
        upd();
        wait_idle("s3");

        // S4: 3-flit packet from 2, out_rdy 1,0,1,0,1, req 0 waiting.
        push_exp(2, 3);
        pkt_q[2].push_back(3);
        upd();
        step();
        push_exp(0, 1);
        pkt_q[0].push_back(1);
        upd();
        #1;
        chk("s4_gnt_oh", arb.gnt_oh, 4'b0100);
        pat = 5'b10101;
        for (int k = 0; k < 5; k++) begin
            arb.out_rdy = pat[k];
            #1;
            chk("s4_req_rdy", arb.req_rdy, pat[k] ? 4'b0100 : 4'b0000);
            step();
        end
        #1;
        chk("s4_gnt_vld_drop", arb.gnt_vld, 0);
        wait_idle("s4");

        // S5: winner 3 drops valid for two cycles while req 1 waits.
        push_exp(3, 3);
        pkt_q[3].push_back(3);
        upd();
        step();
        push_exp(1, 1);
        pkt_q[1].push_back(1);
        upd();
        step();
        hold[3] = 1'b1;
        upd();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("s5_gnt_oh_hold", arb.gnt_oh, 4'b1000);
            chk("s5_req_rdy_hold", arb.req_rdy, 4'b1000);
            step();
        end
        hold[3] = 1'b0;
        upd();
        wait_idle("s5");

        // S6: reset mid-packet from 2 after one flit; afterwards 1001 must
        // see the full mask again (req 0 first), a stale 1100 would pick 3.
        push_exp(2, 1);
        pkt_q[2].push_back(4);
        upd();
        step();
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("s6_async_gnt_vld", arb.gnt_vld, 0);
        chk("s6_async_gnt_oh", arb.gnt_oh, 0);
        chk("s6_async_gnt_idx", arb.gnt_idx, 0);
        chk("s6_async_req_rdy", arb.req_rdy, 0);
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            pkt_q[i].delete();
        end
        hold = '0;
        upd();
        step();
        step();
        rst = 1'b0;
        push_exp(0, 1);
        push_exp(3, 1);
        pkt_q[0].push_back(1);
        pkt_q[3].push_back(1);
        upd();
        wait_idle("s6");

        step();
        step();
        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
